// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// The divider is included only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam int MULDIV_ITER = 32;
  localparam int MULDIV_CNT_W = $clog2(MULDIV_ITER);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One unsigned iteration: shift-add multiply, or restoring compare-subtract
// divide when MULDIV_DIV_EN is defined. Quotient bit is returned separately.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] rem;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path can leave a latch behind.
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
    acc_next = {sum, acc[WIDTH-1:1]};
    q_bit    = 1'b0;
`ifdef MULDIV_DIV_EN
    // Divide layout is {remainder, dividend/quotient}; the quotient bit lands
    // in the vacated LSB, which the caller fills from q_bit.
    rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    if (is_div) begin
      q_bit    = (rem >= {1'b0, operand});
      acc_next = {(q_bit ? (rem[WIDTH-1:0] - operand) : rem[WIDTH-1:0]),
                  acc[WIDTH-2:0], 1'b0};
    end
`else
    if (is_div) acc_next = acc;
`endif
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU/MTHI/MTLO: 33-cycle iterative sequencer.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete as no-ops.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [MULDIV_CNT_W-1:0] LAST_ITER = MULDIV_CNT_W'(MULDIV_ITER - 1);

  state_e                  state;
  logic [MULDIV_CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0]      acc;
  logic [2*WIDTH-1:0]      acc_next;
  logic [WIDTH-1:0]        operand;
  logic                    q_bit;
  logic                    neg_res;
  logic                    neg_rem;
  logic                    is_div;
  logic                    b_zero;

  op_e              op_c;
  logic             mul_op;
  logic             div_op;
  logic             div_skip;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_c = op_e'(op);

  always_comb begin
    mul_op = (op_c == OP_MULT) || (op_c == OP_MULTU);
`ifdef MULDIV_DIV_EN
    div_op   = (op_c == OP_DIV) || (op_c == OP_DIVU);
    div_skip = 1'b0;
`else
    div_op   = 1'b0;
    div_skip = (op_c == OP_DIV) || (op_c == OP_DIVU);
`endif
    a_neg = is_signed_op(op_c) && op_a[WIDTH-1];
    b_neg = is_signed_op(op_c) && op_b[WIDTH-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      is_div   <= 1'b0;
      b_zero   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mul_op || div_op) begin
              // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
              acc     <= {{WIDTH{1'b0}}, (div_op ? a_mag : b_mag)};
              operand <= div_op ? b_mag : a_mag;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              is_div  <= div_op;
              b_zero  <= (op_b == '0);
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= RUN;
            end else if (op_c == OP_MTHI) begin
              hi   <= op_a;
              done <= 1'b1;
            end else if (op_c == OP_MTLO) begin
              lo   <= op_a;
              done <= 1'b1;
            end else if (div_skip) begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= {acc_next[2*WIDTH-1:1], acc_next[0] | q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            // A zero divisor leaves the dividend magnitude as remainder, so the
            // normal sign fix already restores op_a in hi.
            hi       <= neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo       <= b_zero ? {WIDTH{1'b1}}
                               : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
            div_zero <= b_zero;
          end else begin
            {hi, lo} <= neg_res ? -acc : acc;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table, scoreboard, reset and corner sequences.
// Divide vectors follow MULDIV_DIV_EN the same way the RTL does.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        keep_hi;
    logic        keep_lo;
    int          busy_cyc;
    bit          hold;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        sbq[$];
  vec_t        vecs[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Independent reference: native SV arithmetic on full-width values.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic dz,
                       output int nb);
    logic signed [63:0] sa, sb, p;
    int signed          ia, ib;
    h = model_hi; l = model_lo; dz = 1'b0; nb = 33;
    sa = $signed(a); sb = $signed(b); ia = $signed(a); ib = $signed(b);
    case (o)
      3'b000: begin p = sa * sb; {h, l} = p; end
      3'b001: {h, l} = {32'b0, a} * {32'b0, b};
`ifdef MULDIV_DIV_EN
      3'b010, 3'b011: begin
        if (b == 0) begin h = a; l = '1; dz = 1'b1; end
        else if (o == 3'b010 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 0; l = 32'h8000_0000;
        end else if (o == 3'b010) begin l = ia / ib; h = ia % ib; end
        else begin l = a / b; h = a % b; end
      end
`endif
      default: nb = 0;
    endcase
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e, input int e_busy, input bit hold);
    exp_t got;
    int   nb = 0;
    int   guard = 0;
    start = 1'b1; op = o; op_a = a; op_b = b;
    sbq.push_back(e);
    model_hi = e.hi; model_lo = e.lo;
    @(negedge clk);
    while (!done && guard < 100) begin
      if (busy) nb++;
      start = hold; op = OP_MULTU; op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (guard >= 100) begin
      check({name, "_timeout"}, 64'(guard), 64'(e_busy));
      void'(sbq.pop_front());
    end else begin
      if (sbq.size() == 0) check({name, "_sb_empty"}, 1, 0);
      else begin
        got = sbq.pop_front();
        check({name, "_busy_cycles"}, 64'(nb), 64'(e_busy));
        check({name, "_busy_in_done"}, 64'(busy), 0);
        check({name, "_hi"}, 64'(hi), 64'(got.hi));
        check({name, "_lo"}, 64'(lo), 64'(got.lo));
        check({name, "_div_zero"}, 64'(div_zero), 64'(got.dz));
      end
    end
  endtask

  function automatic vec_t mk(string n, logic [2:0] o, logic [31:0] a, logic [31:0] b,
                              logic [31:0] h, logic [31:0] l, logic dz, logic kh, logic kl,
                              int nb, bit hold);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l; v.dz = dz;
    v.keep_hi = kh; v.keep_lo = kl; v.busy_cyc = nb; v.hold = hold;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    int          nb;
    int          seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    vecs.push_back(mk("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 0, 33, 0));
    vecs.push_back(mk("mult_neg3x7_hold", 3'b000, 32'hFFFF_FFFD, 32'd7,
                      32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 0, 33, 1));
    vecs.push_back(mk("mult_minxmin", 3'b000, 32'h8000_0000, 32'h8000_0000,
                      32'h4000_0000, 32'h0, 0, 0, 0, 33, 0));
    vecs.push_back(mk("mthi", 3'b100, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("mtlo", 3'b101, 32'hCAFE_F00D, 32'h0, 0, 32'hCAFE_F00D, 0, 1, 0, 0, 0));
`ifdef MULDIV_DIV_EN
    vecs.push_back(mk("div_neg7_2", 3'b010, 32'hFFFF_FFF9, 32'd2,
                      32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 0, 33, 0));
    vecs.push_back(mk("divu_100_7_b2b", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, 0, 33, 0));
    vecs.push_back(mk("divu_5_0", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0, 0, 33, 0));
    vecs.push_back(mk("div_overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF,
                      32'h0, 32'h8000_0000, 0, 0, 0, 33, 0));
    vecs.push_back(mk("div_neg7_0", 3'b010, 32'hFFFF_FFF9, 32'd0,
                      32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 0, 0, 33, 0));
    vecs.push_back(mk("div_7_neg2", 3'b010, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 0, 0, 33, 0));
`else
    vecs.push_back(mk("div_disabled_9_3", 3'b010, 32'd9, 32'd3, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk("divu_disabled", 3'b011, 32'd100, 32'd7, 0, 0, 0, 1, 1, 0, 0));
`endif

    rst = 1'b0; start = 1'b0; op = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 0);
    check("reset_lo", 64'(lo), 0);
    check("reset_busy", 64'(busy), 0);
    check("reset_done", 64'(done), 0);
    check("reset_div_zero", 64'(div_zero), 0);
    rst = 1'b1;
    @(negedge clk);

    // Each op is issued in the done cycle of the previous one (back-to-back).
    foreach (vecs[i]) begin
      e.hi = vecs[i].keep_hi ? model_hi : vecs[i].hi;
      e.lo = vecs[i].keep_lo ? model_lo : vecs[i].lo;
      e.dz = vecs[i].dz;
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, e, vecs[i].busy_cyc, vecs[i].hold);
    end

    for (int i = 0; i < 6; i++) begin
`ifdef MULDIV_DIV_EN
      ro = 3'($urandom_range(0, 3));
`else
      ro = 3'($urandom_range(0, 1));
`endif
      ra = $urandom;
      rb = (i % 3 == 2) ? 32'($urandom_range(0, 9)) : $urandom;
      model(ro, ra, rb, e.hi, e.lo, e.dz, nb);
      run_op($sformatf("rand%0d", i), ro, ra, rb, e, nb, 0);
    end

    @(negedge clk);
    check("done_single_cycle", 64'(done), 0);

    start = 1'b1; op = 3'b110; op_a = 32'hFFFF_FFFF; op_b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("reserved_done", 64'(done), 0);
    check("reserved_busy", 64'(busy), 0);
    check("reserved_hi", 64'(hi), 64'(model_hi));
    check("reserved_lo", 64'(lo), 64'(model_lo));

    e.hi = 32'h1234; e.lo = model_lo; e.dz = 1'b0;
    run_op("mthi_1234", 3'b100, 32'h1234, 32'h0, e, 0, 0);

    start = 1'b1; op = 3'b000; op_a = 32'd5; op_b = 32'hFFFF_FFFA;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_run_busy", 64'(busy), 1);
    check("mid_run_hi_stable", 64'(hi), 32'h1234);
    rst = 1'b0;
    #1;
    check("rst_async_busy", 64'(busy), 0);
    check("rst_async_hi", 64'(hi), 0);
    check("rst_async_lo", 64'(lo), 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("rst_no_done", 64'(seen), 0);
    model_hi = '0; model_lo = '0;

    e.hi = 32'h0; e.lo = 32'd12; e.dz = 1'b0;
    run_op("multu_after_reset", 3'b001, 32'd3, 32'd4, e, 33, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
